knight_sprite_addr_gen: RTL and testbench

KNIGHT_SPRITE_ADDR_GEN -- requirements
Module: knight_sprite_addr_gen

---
 rtl/knight_sprite_addr_gen_if.sv | 29 ++
 rtl/knight_sprite_addr_gen.sv | 166 ++++++++++++++++
 tb/tb_knight_sprite_addr_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/knight_sprite_addr_gen_if.sv
// rtl/knight_sprite_addr_gen_if.sv - attack handshake and sprite ROM address bundle for the knight sprite
interface knight_sprite_addr_gen_if #(
    parameter int ADDR_W = 14
);
    logic              attack_req;
    logic              attack_ack;
    logic              attack_busy;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_on;
    logic [1:0]        frame_idx;

    modport master (
        output attack_req,
        input  attack_ack,
        input  attack_busy,
        input  rom_address,
        input  sprite_on,
        input  frame_idx
    );

    modport slave (
        input  attack_req,
        output attack_ack,
        output attack_busy,
        output rom_address,
        output sprite_on,
        output frame_idx
    );
endinterface

// File: rtl/knight_sprite_addr_gen.sv
// rtl/knight_sprite_addr_gen.sv - knight sprite ROM addressing with attack animation FSM
// Optional macro KNIGHT_MIRROR_EN enables horizontal mirroring from facing_left.
module knight_sprite_addr_gen #(
    parameter int SPRITE_W   = 50,
    parameter int SPRITE_H   = 64,
    parameter int FRAMES     = 3,
    parameter int FRAME_HOLD = 4,
    parameter int COOLDOWN   = 8,
    parameter int ADDR_W     = 14
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       vs,
    input  logic [9:0] knight_x,
    input  logic [9:0] knight_y,
    input  logic       facing_left,
    knight_sprite_addr_gen_if.slave bus
);
    localparam int          FRAME_SIZE = SPRITE_W * SPRITE_H;
    localparam logic [15:0] HOLD_LAST  = 16'(FRAME_HOLD - 1);
    localparam logic [15:0] COOL_LAST  = 16'(COOLDOWN - 1);
    localparam logic [1:0]  FRAME_LAST = 2'(FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_COOLDOWN
    } state_t;

    state_t      state, state_n;
    logic [15:0] hold_cnt, hold_cnt_n;
    logic [15:0] cool_cnt, cool_cnt_n;
    logic [1:0]  frame_idx, frame_n;
    logic        ack, ack_n;

    logic        vs_q;
    logic        frame_tick;
    logic [9:0]  x_lat, y_lat;

    logic [10:0]       dx, dy, col;
    logic              in_box;
    logic [ADDR_W-1:0] addr_n;

    // Position is sampled once per video frame so the sprite never tears mid-scan.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            vs_q       <= 1'b1;
            frame_tick <= 1'b0;
            x_lat      <= '0;
            y_lat      <= '0;
        end else begin
            vs_q       <= vs;
            frame_tick <= vs & ~vs_q;
            if (frame_tick) begin
                x_lat <= knight_x;
                y_lat <= knight_y;
            end
        end
    end

`ifdef KNIGHT_MIRROR_EN
    logic face_lat;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            face_lat <= 1'b0;
        end else if (frame_tick) begin
            face_lat <= facing_left;
        end
    end

    assign col = face_lat ? (11'(SPRITE_W - 1) - dx) : dx;
`else
    logic unused_facing;
    assign unused_facing = facing_left;
    assign col = dx;
`endif

    // Pixels left of/above the box wrap to large unsigned values and fail the compare.
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, x_lat};
        dy     = {1'b0, DrawY} - {1'b0, y_lat};
        in_box = (dx < 11'(SPRITE_W)) && (dy < 11'(SPRITE_H));
        addr_n = ADDR_W'(frame_idx) * ADDR_W'(FRAME_SIZE)
               + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
               + ADDR_W'(col);
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            bus.sprite_on   <= 1'b0;
            bus.rom_address <= '0;
        end else begin
            bus.sprite_on   <= in_box;
            bus.rom_address <= in_box ? addr_n : '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            hold_cnt  <= '0;
            cool_cnt  <= '0;
            frame_idx <= '0;
            ack       <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            cool_cnt  <= cool_cnt_n;
            frame_idx <= frame_n;
            ack       <= ack_n;
        end
    end

    // A tick coinciding with acceptance is deliberately not counted: IDLE ignores it.
    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        cool_cnt_n = cool_cnt;
        frame_n    = frame_idx;
        ack_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.attack_req) begin
                    state_n    = S_ATTACK;
                    ack_n      = 1'b1;
                    frame_n    = '0;
                    hold_cnt_n = '0;
                end
            end
            S_ATTACK: begin
                if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt_n = '0;
                        if (frame_idx == FRAME_LAST) begin
                            state_n    = S_COOLDOWN;
                            frame_n    = '0;
                            cool_cnt_n = '0;
                        end else begin
                            frame_n = frame_idx + 2'd1;
                        end
                    end else begin
                        hold_cnt_n = hold_cnt + 16'd1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (frame_tick) begin
                    if (cool_cnt == COOL_LAST) begin
                        state_n    = S_IDLE;
                        cool_cnt_n = '0;
                    end else begin
                        cool_cnt_n = cool_cnt + 16'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.attack_ack  = ack;
    assign bus.attack_busy = (state != S_IDLE);
    assign bus.frame_idx   = frame_idx;
endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// tb/tb_knight_sprite_addr_gen.sv - scoreboard bench for knight_sprite_addr_gen
module tb_knight_sprite_addr_gen;
    localparam int SW = 50;
    localparam int SH = 64;
    localparam int FR = 3;
    localparam int FH = 4;
    localparam int CD = 8;
    localparam int AW = 14;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, knight_x, knight_y;
    logic       vs, facing_left;

    knight_sprite_addr_gen_if #(.ADDR_W(AW)) bus ();

    knight_sprite_addr_gen #(
        .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(FR),
        .FRAME_HOLD(FH), .COOLDOWN(CD), .ADDR_W(AW)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n),
        .DrawX(DrawX), .DrawY(DrawY), .vs(vs),
        .knight_x(knight_x), .knight_y(knight_y),
        .facing_left(facing_left), .bus(bus)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int son;
        int addr;
        int fidx;
        int ack;
        int busy;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge vga_clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: animation phase is just "ticks counted since acceptance".
    int m_x, m_y, m_face, m_tick, m_vsprev, m_active, m_ticks;

    function automatic int frame_of();
        return (m_active != 0 && m_ticks < FR * FH) ? m_ticks / FH : 0;
    endfunction

    task automatic model_step();
        exp_t e;
        int dx, dy, col, old_tick;
        e.due = cyc_cnt + 1;
        e.son = 0; e.addr = 0; e.fidx = 0; e.ack = 0; e.busy = 0;
        if (!reset_n) begin
            m_x = 0; m_y = 0; m_face = 0; m_tick = 0; m_vsprev = 1;
            m_active = 0; m_ticks = 0;
        end else begin
            dx  = int'(DrawX) - m_x;
            dy  = int'(DrawY) - m_y;
            col = dx;
`ifdef KNIGHT_MIRROR_EN
            if (m_face != 0) col = SW - 1 - dx;
`endif
            e.son  = (dx >= 0 && dx < SW && dy >= 0 && dy < SH) ? 1 : 0;
            e.addr = (e.son != 0) ? frame_of() * SW * SH + dy * SW + col : 0;
            old_tick = m_tick;
            if (old_tick != 0) begin
                m_x = int'(knight_x); m_y = int'(knight_y); m_face = int'(facing_left);
            end
            m_tick   = (vs && m_vsprev == 0) ? 1 : 0;
            m_vsprev = int'(vs);
            if (m_active == 0) begin
                if (bus.attack_req) begin
                    m_active = 1; m_ticks = 0; e.ack = 1;
                end
            end else if (old_tick != 0) begin
                m_ticks++;
                if (m_ticks == FR * FH + CD) m_active = 0;
            end
            e.fidx = frame_of();
            e.busy = m_active;
        end
        sb.push_back(e);
    endtask

    task automatic cyc();
        model_step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    exp_t me;
    always @(negedge vga_clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc_cnt) begin
            me = sb.pop_front();
            if (me.due < cyc_cnt) begin
                chk("late_entry", cyc_cnt, me.due);
            end else begin
                chk("sprite_on",   int'(bus.sprite_on),   me.son);
                chk("rom_address", int'(bus.rom_address), me.addr);
                chk("frame_idx",   int'(bus.frame_idx),   me.fidx);
                chk("attack_ack",  int'(bus.attack_ack),  me.ack);
                chk("attack_busy", int'(bus.attack_busy), me.busy);
            end
        end
    end

    task automatic pix(int x, int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        cyc();
    endtask

    task automatic rpix();
        int px, py;
        if ($urandom_range(0, 3) == 0) begin
            px = int'(knight_x);
            py = int'(knight_y);
        end else begin
            px = int'(knight_x) + int'($urandom_range(0, 60)) - 5;
            py = int'(knight_y) + int'($urandom_range(0, 74)) - 5;
        end
        if (px < 0) px = 0;
        if (px > 639) px = 639;
        if (py < 0) py = 0;
        if (py > 479) py = 479;
        pix(px, py);
    endtask

    task automatic vsync();
        vs = 1'b0;
        repeat (2) rpix();
        vs = 1'b1;
        repeat (3) rpix();
    endtask

    initial begin
        reset_n = 1'b0; vs = 1'b1; DrawX = '0; DrawY = '0;
        knight_x = '0; knight_y = '0; facing_left = 1'b0;
        bus.attack_req = 1'b0;
        @(posedge vga_clk);
        #1;
        repeat (3) cyc();
        reset_n = 1'b1;

        knight_x = 10'd100; knight_y = 10'd200;
        vsync();
        pix(100, 200); pix(149, 263); pix(150, 263);
        pix(99, 200); pix(100, 199); pix(100, 264);

        facing_left = 1'b1;
        vsync();
        pix(100, 200); pix(149, 200); pix(120, 230);
        facing_left = 1'b0;
        vsync();

        bus.attack_req = 1'b1;
        pix(100, 200);
        bus.attack_req = 1'b0;
        repeat (24) vsync();

        knight_x = 10'd620;
        vsync();
        pix(639, 200); pix(0, 200); pix(619, 200);

        knight_x = 10'd300; knight_y = 10'd100;
        bus.attack_req = 1'b1;
        cyc();
        bus.attack_req = 1'b0;
        repeat (14) vsync();
        bus.attack_req = 1'b1;
        repeat (9) vsync();
        bus.attack_req = 1'b0;
        repeat (24) vsync();

        bus.attack_req = 1'b1;
        cyc();
        bus.attack_req = 1'b0;
        repeat (10) vsync();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();

        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                knight_x    = 10'($urandom_range(0, 639));
                knight_y    = 10'($urandom_range(0, 479));
                facing_left = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 5) == 0) vs = ~vs;
            bus.attack_req = ($urandom_range(0, 9) == 0);
            reset_n = ($urandom_range(0, 599) != 0);
            rpix();
        end
        reset_n = 1'b1;
        bus.attack_req = 1'b0;

        repeat (3) @(posedge vga_clk);
        #1;
        if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
